// File: rtl/prog_timer_pkg.sv
// Shared definitions for the programmable timer: FSM state encoding and count-mode constants.
package prog_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for prog_timer: emits one step every div_i+1 enabled cycles.
module timer_prescaler
  import prog_timer_pkg::*;
#(
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [PSC_WIDTH-1:0] div_i,
  output logic                 step_o
);

  localparam logic [PSC_WIDTH-1:0] ONE = PSC_WIDTH'(1);

  logic [PSC_WIDTH-1:0] count;

  // A clear request wins over a step so a start/stop never produces a count step.
  assign step_o = en_i && !clr_i && (count == div_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count <= '0;
    end else if (clr_i || step_o) begin
      count <= '0;
    end else if (en_i) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable timer with prescaler, one-shot/periodic modes, tick pulse and sticky done flag.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [WIDTH-1:0]     tl_i,
  output logic [WIDTH-1:0]     cnt_o,
  output logic                 tick_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e               state_q;
  state_e               state_d;
  logic                 mode_q;
  logic [PSC_WIDTH-1:0] psc_q;
  logic [WIDTH-1:0]     tl_q;
  logic [WIDTH-1:0]     cnt_q;
  logic                 tick_q;
  logic                 done_q;
  logic                 step;
  logic                 terminal;

  timer_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_prescaler (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .clr_i (start_i | stop_i),
    .en_i  ((state_q == RUN) && en_i),
    .div_i (psc_q),
    .step_o(step)
  );

  assign terminal = step && (cnt_q == tl_q);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stop beats start; a one-shot terminal event parks the timer in DONE.
  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = RUN;
    end else if (terminal && (mode_q == MODE_ONESHOT)) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mode_q <= MODE_ONESHOT;
      psc_q  <= '0;
      tl_q   <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (!stop_i) begin
        if (start_i) begin
          mode_q <= mode_i;
          psc_q  <= psc_i;
          tl_q   <= tl_i;
          cnt_q  <= '0;
          done_q <= 1'b0;
        end else if (terminal) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            done_q <= 1'b1;
          end
        end else if (step) begin
          cnt_q <= cnt_q + ONE;
        end
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign tick_o = tick_q;
  assign busy_o = (state_q == RUN);
  assign done_o = done_q;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: stimulus queues expected outputs per cycle, a monitor compares them.
module tb_prog_timer;

  localparam int WIDTH     = 20;
  localparam int PSC_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 en;
  logic                 start;
  logic                 stop;
  logic                 mode;
  logic [PSC_WIDTH-1:0] psc;
  logic [WIDTH-1:0]     tl;
  logic [WIDTH-1:0]     cnt;
  logic                 tick;
  logic                 busy;
  logic                 done;

  prog_timer #(
    .WIDTH    (WIDTH),
    .PSC_WIDTH(PSC_WIDTH)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .en_i   (en),
    .start_i(start),
    .stop_i (stop),
    .mode_i (mode),
    .psc_i  (psc),
    .tl_i   (tl),
    .cnt_o  (cnt),
    .tick_o (tick),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               at;
    string            tag;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc++;

  // Queue the outputs expected d cycles from now.
  task automatic expect_at(input int d, input string tag, input logic [WIDTH-1:0] c,
                           input logic t, input logic b, input logic dn);
    exp_t e;
    e.at   = cyc + d;
    e.tag  = tag;
    e.cnt  = c;
    e.tick = t;
    e.busy = b;
    e.done = dn;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (cnt !== e.cnt || tick !== e.tick || busy !== e.busy || done !== e.done) begin
      bad++;
      $display("[TB] FAIL %s @cyc %0d: got cnt=%0d tick=%b busy=%b done=%b, want cnt=%0d tick=%b busy=%b done=%b",
               e.tag, cyc, cnt, tick, busy, done, e.cnt, e.tick, e.busy, e.done);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL %s: check for cyc %0d missed, now cyc %0d", e.tag, e.at, cyc);
      end else begin
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic m, input logic [PSC_WIDTH-1:0] p, input logic [WIDTH-1:0] t);
    mode  = m;
    psc   = p;
    tl    = t;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
  endtask

  initial begin
    rstn  = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    psc   = '0;
    tl    = '0;

    applyStimulus(2);
    expect_at(0, "reset", 0, 0, 0, 0);
    rstn = 1'b1;
    applyStimulus(2);
    expect_at(0, "idle_after_reset", 0, 0, 0, 0);

    // periodic, psc=0, tl=3: count 0..3, tick every 4 cycles
    pulse_start(1'b1, 8'd0, 20'd3);
    for (int d = 0; d <= 13; d++)
      expect_at(d, "periodic_tl3", WIDTH'(d % 4), (d > 0) && (d % 4 == 0), 1'b1, 1'b0);
    applyStimulus(13);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    expect_at(0, "stop_holds_cnt", 1, 0, 0, 0);
    expect_at(3, "idle_holds", 1, 0, 0, 0);
    applyStimulus(3);

    // one-shot, psc=2, tl=1: single tick 6 cycles after RUN entry
    pulse_start(1'b0, 8'd2, 20'd1);
    for (int d = 0; d <= 9; d++)
      expect_at(d, "oneshot", (d >= 3 && d <= 5) ? 20'd1 : 20'd0, d == 6, d < 6, d >= 6);
    applyStimulus(9);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    expect_at(0, "stop_in_done", 0, 0, 0, 1);

    // tl=0 periodic: tick every cycle from the second RUN cycle
    pulse_start(1'b1, 8'd0, 20'd0);
    for (int d = 0; d <= 5; d++)
      expect_at(d, "tl0", 0, d > 0, 1'b1, 1'b0);
    applyStimulus(5);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    expect_at(0, "stop_tl0", 0, 0, 0, 0);

    // en low for 5 cycles mid-count, tl_i change ignored during RUN
    pulse_start(1'b1, 8'd0, 20'd9);
    for (int d = 0; d <= 3; d++)
      expect_at(d, "en_pre", WIDTH'(d), 0, 1, 0);
    for (int d = 4; d <= 8; d++)
      expect_at(d, "en_frozen", 3, 0, 1, 0);
    expect_at(9, "en_resume", 4, 0, 1, 0);
    expect_at(14, "en_cnt9", 9, 0, 1, 0);
    expect_at(15, "en_tick_delayed", 0, 1, 1, 0);
    expect_at(16, "en_after_tick", 1, 0, 1, 0);
    applyStimulus(1);
    tl = 20'd2;
    applyStimulus(2);
    en = 1'b0;
    applyStimulus(5);
    en = 1'b1;
    applyStimulus(8);
    start = 1'b1;
    stop  = 1'b1;
    mode  = 1'b0;
    tl    = 20'd5;
    applyStimulus(1);
    start = 1'b0;
    stop  = 1'b0;
    expect_at(0, "start_stop_same_cycle", 1, 0, 0, 0);
    applyStimulus(2);

    // reset mid-run at cnt=5
    pulse_start(1'b1, 8'd0, 20'd9);
    for (int d = 0; d <= 5; d++)
      expect_at(d, "pre_reset_run", WIDTH'(d), 0, 1, 0);
    applyStimulus(5);
    rstn = 1'b0;
    applyStimulus(1);
    rstn = 1'b1;
    expect_at(0, "reset_mid_run", 0, 0, 0, 0);
    expect_at(1, "idle_after_mid_reset", 0, 0, 0, 0);
    applyStimulus(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++)
      applyStimulus(1);
    if (sb.size() > 0) begin
      $display("[TB] FAIL drain: %0d checks pending, required 0", sb.size());
      total += sb.size();
      bad   += sb.size();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
